// File: rtl/instr_mem_loader.sv
// Boot-time program loader: receives a length-prefixed byte stream, packs
// big-endian 32-bit words and writes them to instruction memory. The core
// is held in reset (cpu_run=0) until the whole image has been written.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset, waiting for start; stream not consumed
// S_LEN_HI | waiting for the high byte of the word count
// S_LEN_LO | waiting for the low byte; decides empty / too big / load
// S_DATA   | collecting the 4 bytes of the current word
// S_WRITE  | one-cycle memory write of the assembled word
// S_DONE   | image complete, core released
// S_ERR    | word count exceeded capacity, core stays in reset
module instr_mem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Length arithmetic is done in 17 bits so that a full 2**ADDR_W image
  // (ADDR_W up to 16) compares cleanly against the 16-bit word count.
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       n_words;
  logic [ADDR_W-1:0] index;
  logic [1:0]        byte_cnt;
  logic [23:0]       shreg;
  logic              accept;
  logic [15:0]       len_full;
  logic              last_word;

  assign accept    = in_valid & in_ready;
  assign len_full  = {n_words[15:8], in_data};
  assign last_word = (({{(17-ADDR_W){1'b0}}, index} + 17'd1) == {1'b0, n_words});

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and Moore outputs; handshake decisions use in_valid directly
  // because in_ready is already implied by the state being decoded.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_run   = 1'b0;
    mem_we    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (len_full == 16'd0)                state_nxt = S_DONE;
          else if ({1'b0, len_full} > CAPACITY) state_nxt = S_ERR;
          else                                  state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && byte_cnt == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        state_nxt = last_word ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done    = 1'b1;
        cpu_run = 1'b1;
        if (start) state_nxt = S_LEN_HI;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_nxt = S_LEN_HI;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Length capture, word assembly and write address/data registers.
  // mem_addr/mem_wdata are loaded on the 4th byte so they are stable for
  // the whole WRITE cycle and simply hold afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_words   <= '0;
      index     <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_LEN_HI: begin
          if (accept) n_words[15:8] <= in_data;
        end
        S_LEN_LO: begin
          if (accept) begin
            n_words[7:0] <= in_data;
            index        <= '0;
            byte_cnt     <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            shreg    <= {shreg[15:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_wdata <= {shreg, in_data};
              mem_addr  <= index;
            end
          end
        end
        S_WRITE: begin
          if (!last_word) index <= index + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
